// File: rtl/speed_pkg.sv
// Shared types and helpers for the quadrature speed meter.
// Contents:
//   quad_state_t : measurement FSM state (IDLE = no reference edge, RUN = measuring).
//   quad_event_t : result of decoding one (previous, current) AB sample pair.
//   DIR_FWD/REV  : direction encoding, shared with the speed generator's dir input.
//   quad_decode  : 4x4 (prev, cur) decode in x4 mode, AB packed as {A, B}.
package speed_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } quad_state_t;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_FWD  = 2'd1,
    EV_REV  = 2'd2,
    EV_ILL  = 2'd3
  } quad_event_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // Successor of an AB state in the forward (A leads B) sequence 00->10->11->01->00.
  function automatic logic [1:0] fwd_next(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // A Gray-coded step changes exactly one bit; a two-bit change means a sample
  // was missed and the direction cannot be known.
  function automatic quad_event_t quad_decode(input logic [1:0] prev, input logic [1:0] cur);
    if (cur == prev)                return EV_NONE;
    else if (cur == ~prev)          return EV_ILL;
    else if (cur == fwd_next(prev)) return EV_FWD;
    else                            return EV_REV;
  endfunction

endpackage

// File: rtl/quad_sync.sv
// Two-flop synchronizer for one quadrature AB pair plus a register holding the
// previous synchronized value, so the decoder sees (prev, cur) on the same cycle.
// Ports:
//   clk, rst : clock, asynchronous active-low reset (all flops clear to 00)
//   a, b     : raw channels, asynchronous to clk
//   cur      : synchronized {A, B}
//   prev     : cur delayed by one clk
module quad_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  output logic [1:0] cur,
  output logic [1:0] prev
);

  logic [1:0] meta;

  // NOTE: non-blocking assignments make each stage capture the previous stage's
  // old value; blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 2'b00;
      cur  <= 2'b00;
      prev <= 2'b00;
    end else begin
      meta <= {a, b};
      cur  <= meta;
      prev <= cur;
    end
  end

endmodule

// File: rtl/quad_speed_meter.sv
// Quadrature decoder and speed meter (x4 mode).
// Tracks signed position, last direction, and the clk-cycle interval between
// consecutive same-direction valid edges; flags stalls and counts illegal
// (double-bit) transitions.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   A, B         : quadrature channels, asynchronous to clk
//   clr_pos      : synchronous position clear, overrides that cycle's edge
//   dir          : last valid direction (1 = forward, A leads B)
//   pos          : signed position in quarter-counts, wraps
//   period       : cycles between the last two same-direction edges, 0 = unknown
//   period_valid : one-cycle pulse when period updates
//   stall        : no valid edge for TIMEOUT cycles
//   err_cnt      : saturating count of illegal transitions
module quad_speed_meter
  import speed_pkg::*;
#(
  parameter int          CNT_W   = 26,
  parameter int          POS_W   = 32,
  parameter int unsigned TIMEOUT = 2**26 - 1,
  parameter int          ERR_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    A,
  input  logic                    B,
  input  logic                    clr_pos,
  output logic                    dir,
  output logic signed [POS_W-1:0] pos,
  output logic        [CNT_W-1:0] period,
  output logic                    period_valid,
  output logic                    stall,
  output logic        [ERR_W-1:0] err_cnt
);

  localparam logic        [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic        [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic        [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic signed [POS_W-1:0] POS_ONE   = POS_W'(1);

  logic [1:0]  ab_cur;
  logic [1:0]  ab_prev;
  quad_event_t ev;
  logic        ev_valid;
  logic        ev_dir;
  logic        timeout;

  quad_state_t      state, state_nxt;
  logic             dir_nxt;
  logic [CNT_W-1:0] period_nxt;
  logic             pv_nxt;
  logic             stall_nxt;
  logic [CNT_W-1:0] icnt;

  quad_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .a    (A),
    .b    (B),
    .cur  (ab_cur),
    .prev (ab_prev)
  );

  assign ev       = quad_decode(ab_prev, ab_cur);
  assign ev_valid = (ev == EV_FWD) || (ev == EV_REV);
  assign ev_dir   = (ev == EV_FWD) ? DIR_FWD : DIR_REV;
  // Compared against icnt before this cycle's increment, so an edge arriving
  // on the timeout cycle is still measured rather than declared a stall.
  assign timeout  = (icnt == TIMEOUT_C);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      dir          <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      stall        <= 1'b1;
    end else begin
      state        <= state_nxt;
      dir          <= dir_nxt;
      period       <= period_nxt;
      period_valid <= pv_nxt;
      stall        <= stall_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_nxt  = state;
    dir_nxt    = dir;
    period_nxt = period;
    pv_nxt     = 1'b0;
    stall_nxt  = stall;
    case (state)
      IDLE: begin
        // First edge only establishes the reference point and direction.
        if (ev_valid) begin
          dir_nxt   = ev_dir;
          stall_nxt = 1'b0;
          state_nxt = RUN;
        end else if (ev == EV_NONE && timeout) begin
          stall_nxt = 1'b1;
        end
      end
      RUN: begin
        if (ev_valid) begin
          if (ev_dir == dir) begin
            period_nxt = icnt;
            pv_nxt     = 1'b1;
          end else begin
            // Reversal: the interval spans two directions and is meaningless.
            dir_nxt    = ev_dir;
            period_nxt = '0;
          end
        end else if (ev == EV_ILL) begin
          state_nxt = IDLE;
        end else if (timeout) begin
          stall_nxt  = 1'b1;
          period_nxt = '0;
          state_nxt  = IDLE;
        end
      end
    endcase
  end

  // Interval counter: loads 1 on an edge so that edges N cycles apart read N.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      icnt <= '0;
    end else if (ev == EV_ILL) begin
      icnt <= '0;
    end else if (ev_valid) begin
      icnt <= CNT_W'(1);
    end else if (icnt != CNT_MAX) begin
      icnt <= icnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos <= '0;
    end else if (clr_pos) begin
      pos <= '0;
    end else if (ev == EV_FWD) begin
      pos <= pos + POS_ONE;
    end else if (ev == EV_REV) begin
      pos <= pos - POS_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (ev == EV_ILL && err_cnt != ERR_MAX) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule
